// File: rtl/mdu.sv
// mdu: multiply/divide unit for the EX stage.
// Holds the architectural HI/LO registers. Runs multi-cycle MULT/MULTU/DIV/DIVU
// (and MADD/MADDU when built with MDU_MADD_EN) and single-cycle MTHI/MTLO.
// Optional feature macro: MDU_MADD_EN enables the MADD/MADDU accumulate ops.
//
// Handshake: start is a one-cycle qualifier for op/A/B, with no ready signal.
// In IDLE, an MDU op with start=1 is accepted at that rising edge. While busy=1
// (RUN), start is ignored entirely, so the hazard unit must hold the instruction
// until busy drops. busy comes straight from the state flop.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   a_q, b_q;
  logic [3:0]    op_q;
  logic          latch_en;
  logic [31:0]   hi_next, lo_next;

  logic          is_mul_op, is_div_op;
  logic          q_is_mul, q_signed;
  logic [63:0]   prod, mul_res;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // Decode the incoming op into the multi-cycle classes it can start.
  always_comb begin
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
`else
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
`endif
  end

  // Result datapath, driven only by the latched operands and latched op.
  always_comb begin
    q_is_mul = !((op_q == OP_DIV) || (op_q == OP_DIVU));
    q_signed = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);
    prod     = q_signed ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                        : ({32'd0, a_q} * {32'd0, b_q});
`ifdef MDU_MADD_EN
    mul_res  = ((op_q == OP_MADD) || (op_q == OP_MADDU)) ? ({HI, LO} + prod) : prod;
`else
    mul_res  = prod;
`endif
    // Signed divide works on magnitudes, so 0x80000000 / -1 naturally yields
    // 0x80000000 with remainder 0 instead of overflowing.
    a_neg    = q_signed & a_q[31];
    b_neg    = q_signed & b_q[31];
    a_mag    = a_neg ? (32'd0 - a_q) : a_q;
    b_mag    = b_neg ? (32'd0 - b_q) : b_q;
    b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state, counter and HI/LO write selection.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    hi_next    = HI;
    lo_next    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_mul_op) begin
            latch_en   = 1'b1;
            cnt_next   = CW'(MULT_CYCLES);
            state_next = RUN;
          end else if (is_div_op) begin
            latch_en   = 1'b1;
            cnt_next   = CW'(DIV_CYCLES);
            state_next = RUN;
          end else if (op == OP_MTHI) begin
            hi_next = A;
          end else if (op == OP_MTLO) begin
            lo_next = A;
          end
        end
      end
      RUN: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_next = IDLE;
          if (q_is_mul) begin
            {hi_next, lo_next} = mul_res;
          end else if (b_q != 32'd0) begin
            // Divide by zero leaves HI/LO untouched after the full busy period.
            {hi_next, lo_next} = {rem, quot};
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, operand latches and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      HI    <= hi_next;
      LO    <= lo_next;
      if (latch_en) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu with a {HI,LO} scoreboard queue.
module tb_mdu;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd8;
`ifdef MDU_MADD_EN
  localparam int MADD_N = 5;
`else
  localparam int MADD_N = 0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  op;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  logic [63:0] exp_q[$];
  logic [63:0] mdl;
  int          pass_cnt;
  int          chk_cnt;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: next {HI,LO} for an op given the current {HI,LO}.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    logic [63:0] r;
    longint      sa64, sb64;
    int          sa, sb;
    r = cur;
    sa64 = longint'(signed'(a));
    sb64 = longint'(signed'(b));
    sa = a;
    sb = b;
    case (o)
      OP_MULT:  r = 64'(sa64 * sb64);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b != 32'd0) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
          else r = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      OP_DIVU:  if (b != 32'd0) r = {a % b, a / b};
      OP_MTHI:  r = {a, cur[31:0]};
      OP_MTLO:  r = {cur[63:32], a};
`ifdef MDU_MADD_EN
      4'd7:     r = cur + 64'(sa64 * sb64);
      OP_MADDU: r = cur + ({32'd0, a} * {32'd0, b});
`endif
      default:  r = cur;
    endcase
    return r;
  endfunction

  // Count busy cycles from the current cycle until busy drops (bounded).
  task automatic wait_done(output int c);
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      c++;
      tick();
    end
  endtask

  // Drive one op, push its expected {HI,LO}, scramble operands, wait for idle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int c);
    exp_q.push_back(model(o, a, b, mdl));
    mdl   = exp_q[$];
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 4'd0;
    A     = $urandom;
    B     = $urandom;
    wait_done(c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = 4'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    mdl   = 64'd0;
    tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (HI !== 32'd0) $display("FAIL reset_hi got %h want 0", HI); else pass_cnt++;
    chk_cnt++; if (LO !== 32'd0) $display("FAIL reset_lo got %h want 0", LO); else pass_cnt++;
  endtask

  task automatic test_mult();
    int c;
    logic [63:0] e;
    logic [31:0] ra, rb;
    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, c);
    e = exp_q.pop_front();
    chk_cnt++; if (c !== 5) $display("FAIL mult_busy got %0d want 5", c); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL mult_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
    run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, c);
    e = exp_q.pop_front();
    chk_cnt++; if (c !== 5) $display("FAIL multu_busy got %0d want 5", c); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL multu_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op((i % 2 == 0) ? OP_MULT : OP_MULTU, ra, rb, c);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({HI, LO} !== e) $display("FAIL mult_rand%0d got %h want %h", i, {HI, LO}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_div();
    int c;
    logic [63:0] e;
    logic [31:0] ra, rb;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, c);
    e = exp_q.pop_front();
    chk_cnt++; if (c !== 10) $display("FAIL div_busy got %0d want 10", c); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL div_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
    run_op(OP_DIVU, 32'd7, 32'd2, c);
    e = exp_q.pop_front();
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL divu_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, c);
    e = exp_q.pop_front();
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL div_ovf got %h want %h", {HI, LO}, e); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 70000);
      if (i == 1) rb = 32'd0 - rb;
      run_op((i < 2) ? OP_DIV : OP_DIVU, ra, rb, c);
      e = exp_q.pop_front();
      chk_cnt++;
      if ({HI, LO} !== e) $display("FAIL div_rand%0d got %h want %h", i, {HI, LO}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_mthi_divzero();
    int c;
    logic [63:0] e;
    run_op(OP_MTHI, 32'h12345678, 32'd0, c);
    e = exp_q.pop_front();
    chk_cnt++; if (c !== 0) $display("FAIL mthi_busy got %0d want 0", c); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL mthi_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
    run_op(OP_MTLO, 32'hCAFEF00D, 32'd0, c);
    e = exp_q.pop_front();
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL mtlo_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
    run_op(OP_DIV, 32'd1234, 32'd0, c);
    e = exp_q.pop_front();
    chk_cnt++; if (c !== 10) $display("FAIL divzero_busy got %0d want 10", c); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL divzero_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c;
    logic [63:0] e;
    exp_q.push_back(model(OP_DIV, 32'd100, 32'd7, mdl));
    mdl   = exp_q[$];
    op    = OP_DIV;
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 4'd0;
    tick();
    tick();
    // Third RUN cycle: an MTLO and new operands must all be ignored.
    op    = OP_MTLO;
    A     = 32'h0000DEAD;
    B     = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 4'd0;
    A     = 32'd5;
    B     = 32'd9;
    wait_done(c);
    c = c + 3;
    e = exp_q.pop_front();
    chk_cnt++; if (c !== 10) $display("FAIL ignore_busy got %0d want 10", c); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL ignore_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
    // Issued in the very cycle busy fell.
    run_op(OP_MULT, 32'h00001234, 32'hFFFFFFF0, c);
    e = exp_q.pop_front();
    chk_cnt++; if (c !== 5) $display("FAIL b2b_busy got %0d want 5", c); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL b2b_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    op    = OP_MULT;
    A     = 32'd7;
    B     = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 4'd0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl   = 64'd0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== 64'd0) $display("FAIL rstmid_hilo got %h want 0", {HI, LO}); else pass_cnt++;
    repeat (8) tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_late_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== 64'd0) $display("FAIL rstmid_late_hilo got %h want 0", {HI, LO}); else pass_cnt++;
  endtask

  task automatic test_madd();
    int c;
    logic [63:0] e;
    run_op(OP_MTHI, 32'd0, 32'd0, c);
    e = exp_q.pop_front();
    run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, c);
    e = exp_q.pop_front();
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL madd_setup got %h want %h", {HI, LO}, e); else pass_cnt++;
    run_op(OP_MADDU, 32'd1, 32'd1, c);
    e = exp_q.pop_front();
    chk_cnt++; if (c !== MADD_N) $display("FAIL maddu_busy got %0d want %0d", c, MADD_N); else pass_cnt++;
    chk_cnt++; if ({HI, LO} !== e) $display("FAIL maddu_hilo got %h want %h", {HI, LO}, e); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    mdl      = 64'd0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_divzero();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
